// File: rtl/load_pkg.sv
// Shared definitions for the memory-stage load path: load-type encodings,
// the load FSM state, the captured-request record and the lane helpers.
package load_pkg;

  localparam logic [2:0] LD_B  = 3'b000;
  localparam logic [2:0] LD_H  = 3'b001;
  localparam logic [2:0] LD_W  = 3'b010;
  localparam logic [2:0] LD_BU = 3'b100;
  localparam logic [2:0] LD_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } ld_state_e;

  // Load captured when it leaves IDLE
  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  ltype;
    logic [4:0]  rd;
  } ld_req_t;

  // Natural alignment per type; the illegal encodings report as misaligned
  function automatic logic ld_aligned(input logic [2:0] t, input logic [1:0] a);
    logic ok;
    case (t)
      LD_B, LD_BU: ok = 1'b1;
      LD_H, LD_HU: ok = ~a[0];
      LD_W:        ok = (a == 2'b00);
      default:     ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Select the byte/half lane from a word and sign- or zero-extend it
  function automatic logic [31:0] lane_extract(input logic [2:0]  t,
                                               input logic [1:0]  a,
                                               input logic [31:0] d);
    logic [31:0] sh;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    sh = d >> {a, 3'b000};
    b  = sh[7:0];
    h  = a[1] ? d[31:16] : d[15:0];
    case (t)
      LD_B:    r = {{24{b[7]}}, b};
      LD_BU:   r = {24'h0, b};
      LD_H:    r = {{16{h[15]}}, h};
      LD_HU:   r = {16'h0, h};
      LD_W:    r = d;
      default: r = 32'h0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/load_extract.sv
// Combinational lane extraction: (type, addr[1:0], word) -> extended result.
// Kept as its own block so the store path can reuse it for lane checks.
module load_extract
  import load_pkg::*;
(
  input  logic [2:0]  i_type,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_data
);

  // Pure function of the inputs
  always_comb begin
    o_data = lane_extract(i_type, i_addr_lo, i_rdata);
  end

endmodule

// File: rtl/load_resp_unit.sv
// Memory-stage load engine: issues a word read with req/ack, extends the
// returned lane, stalls upstream while the load is outstanding and honours
// flush by killing the writeback. Optional bus timeout is built only when
// LOAD_RESP_TIMEOUT_EN is defined; otherwise bus_err is tied low.
module load_resp_unit
  import load_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld_valid_l3,
  input  logic [2:0]  ld_type_l3,
  input  logic [31:0] alu_q_l3,
  input  logic [4:0]  rd_l3,
  input  logic        flush,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        block_out,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        misalign_exc,
  output logic        bus_err
);

  ld_state_e   r_state, w_next;
  ld_req_t     r_req;
  logic        r_kill;
  logic [4:0]  r_wb_rd;
  logic [31:0] r_wb_data;
  logic        r_misalign;
  logic        w_aligned;
  logic        w_take;
  logic        w_timeout;
  logic [31:0] w_ext;

  assign w_aligned = ld_aligned(ld_type_l3, alu_q_l3[1:0]);
  assign w_take    = (r_state == ST_IDLE) & ld_valid_l3 & w_aligned & ~flush;

  load_extract u_extract (
    .i_type    (r_req.ltype),
    .i_addr_lo (r_req.addr[1:0]),
    .i_rdata   (mem_rdata),
    .o_data    (w_ext)
  );

`ifdef LOAD_RESP_TIMEOUT_EN
  logic [CNT_W-1:0] r_cnt;
  logic             r_bus_err;

  // REQ-cycle counter, restarted on every accepted load
  always_ff @(posedge clk) begin
    if (rst)                     r_cnt <= '0;
    else if (w_take)             r_cnt <= '0;
    else if (r_state == ST_REQ)  r_cnt <= r_cnt + 1'b1;
  end

  assign w_timeout = (r_state == ST_REQ) & ~mem_ack &
                     (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // One-cycle error pulse following the abandoned request
  always_ff @(posedge clk) begin
    if (rst) r_bus_err <= 1'b0;
    else     r_bus_err <= w_timeout;
  end

  assign bus_err = r_bus_err;
`else
  assign w_timeout = 1'b0;
  assign bus_err   = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic; REQ only leaves on ack (or timeout when built)
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_take) w_next = ST_REQ;
      ST_REQ: begin
        if (mem_ack)        w_next = ST_DONE;
        else if (w_timeout) w_next = ST_IDLE;
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // State-decoded outputs; block drops in DONE so the pipe moves on writeback
  always_comb begin
    mem_req   = (r_state == ST_REQ);
    wb_valid  = (r_state == ST_DONE) & ~r_kill;
    block_out = w_take | (r_state == ST_REQ);
  end

  // Capture, kill tracking, result latch and misalign pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      r_req      <= '0;
      r_kill     <= 1'b0;
      r_wb_rd    <= '0;
      r_wb_data  <= '0;
      r_misalign <= 1'b0;
    end else begin
      if (w_take) begin
        r_req.addr  <= alu_q_l3;
        r_req.ltype <= ld_type_l3;
        r_req.rd    <= rd_l3;
        r_kill      <= 1'b0;
      end else if ((r_state == ST_REQ) && flush) begin
        r_kill <= 1'b1;
      end
      if ((r_state == ST_REQ) && mem_ack) begin
        r_wb_data <= w_ext;
        r_wb_rd   <= r_req.rd;
      end
      r_misalign <= (r_state == ST_IDLE) & ld_valid_l3 & ~w_aligned & ~flush;
    end
  end

  assign mem_addr     = {r_req.addr[31:2], 2'b00};
  assign wb_rd        = r_wb_rd;
  assign wb_data      = r_wb_data;
  assign misalign_exc = r_misalign;

endmodule
